// File: rtl/load_store_unit_if.sv
// Bundle of EX request, data-memory and writeback signals around the load/store unit.
// master = the load/store unit itself, slave = its environment (EX stage, data memory, writeback).
interface load_store_unit_if #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RD_W     = 3,
    parameter int SB_DEPTH = 4
);
    localparam int CNT_W = $clog2(SB_DEPTH) + 1;

    logic              ex_valid;
    logic              ex_is_load;
    logic              ex_is_store;
    logic [ADDR_W-1:0] ex_addr;
    logic [DATA_W-1:0] ex_wdata;
    logic [RD_W-1:0]   ex_rd;
    logic              lsu_stall;
    logic              mem_read;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              wb_valid;
    logic [RD_W-1:0]   wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic [CNT_W-1:0]  sb_count;

    modport master (
        input  ex_valid, ex_is_load, ex_is_store, ex_addr, ex_wdata, ex_rd, mem_rdata,
        output lsu_stall, mem_read, mem_write, mem_addr, mem_wdata,
        output wb_valid, wb_rd, wb_data, sb_count
    );

    modport slave (
        output ex_valid, ex_is_load, ex_is_store, ex_addr, ex_wdata, ex_rd, mem_rdata,
        input  lsu_stall, mem_read, mem_write, mem_addr, mem_wdata,
        input  wb_valid, wb_rd, wb_data, sb_count
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: FIFO store buffer drained to the data memory, 3-cycle memory load path.
// Optional macro STORE_FWD_EN: loads hitting a buffered store are served from the buffer.
module load_store_unit #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 8,
    parameter int RD_W     = 3,
    parameter int SB_DEPTH = 4
) (
    input  logic               i_clk,
    input  logic               i_reset,
    load_store_unit_if.master  bus
);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LD_ADDR = 2'd1;
    localparam logic [1:0] S_LD_DATA = 2'd2;

    logic [1:0]        r_state;
    logic [ADDR_W-1:0] r_sb_addr [SB_DEPTH];
    logic [DATA_W-1:0] r_sb_data [SB_DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;
    logic [RD_W-1:0]   r_ld_rd;
    logic              r_mem_read;
    logic              r_mem_write;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_wb_valid;
    logic [RD_W-1:0]   r_wb_rd;
    logic [DATA_W-1:0] r_wb_data;

    logic              w_is_store;
    logic              w_is_load;
    logic              w_sb_full;
    logic              w_sb_empty;
    logic              w_ld_block;
    logic              w_stall;
    logic              w_acc_st;
    logic              w_acc_ld;
    logic              w_ld_mem;
    logic              w_pop;
    logic              w_fwd_hit;
    logic [DATA_W-1:0] w_fwd_data;

    // A simultaneous load+store request is treated as a store.
    assign w_is_store = bus.ex_is_store;
    assign w_is_load  = bus.ex_is_load & ~bus.ex_is_store;
    assign w_sb_full  = (r_count == CNT_W'(SB_DEPTH));
    assign w_sb_empty = (r_count == CNT_W'(0));

`ifdef STORE_FWD_EN
    assign w_ld_block = 1'b0;

    // Youngest matching buffered entry wins; later iterations are younger.
    always_comb begin : fwd_scan
        logic [PTR_W-1:0] v_idx;
        w_fwd_hit  = 1'b0;
        w_fwd_data = {DATA_W{1'b0}};
        v_idx      = r_head;
        for (int i = 0; i < SB_DEPTH; i++) begin
            v_idx = r_head + PTR_W'(i);
            if ((CNT_W'(i) < r_count) && (r_sb_addr[v_idx] == bus.ex_addr)) begin
                w_fwd_hit  = 1'b1;
                w_fwd_data = r_sb_data[v_idx];
            end else begin
                w_fwd_hit  = w_fwd_hit;
            end
        end
    end
`else
    assign w_ld_block = ~w_sb_empty;
    assign w_fwd_hit  = 1'b0;
    assign w_fwd_data = {DATA_W{1'b0}};
`endif

    assign w_stall  = (r_state != S_IDLE)
                    | (bus.ex_valid & w_is_store & w_sb_full)
                    | (bus.ex_valid & w_is_load & w_ld_block);
    assign w_acc_st = bus.ex_valid & ~w_stall & w_is_store;
    assign w_acc_ld = bus.ex_valid & ~w_stall & w_is_load;
    assign w_ld_mem = w_acc_ld & ~w_fwd_hit;
    // The port is given to a load in its accept cycle; any other cycle drains one store.
    assign w_pop    = ~w_sb_empty & ~w_acc_ld;

    assign bus.lsu_stall = w_stall;
    assign bus.mem_read  = r_mem_read;
    assign bus.mem_write = r_mem_write;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign bus.wb_valid  = r_wb_valid;
    assign bus.wb_rd     = r_wb_rd;
    assign bus.wb_data   = r_wb_data;
    assign bus.sb_count  = r_count;

    // Store buffer storage, pointers and occupancy.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_head  <= PTR_W'(0);
            r_tail  <= PTR_W'(0);
            r_count <= CNT_W'(0);
            for (int i = 0; i < SB_DEPTH; i++) begin
                r_sb_addr[i] <= {ADDR_W{1'b0}};
                r_sb_data[i] <= {DATA_W{1'b0}};
            end
        end else begin
            if (w_acc_st) begin
                r_sb_addr[r_tail] <= bus.ex_addr;
                r_sb_data[r_tail] <= bus.ex_wdata;
                r_tail            <= r_tail + PTR_W'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PTR_W'(1);
            end
            r_count <= r_count + CNT_W'(w_acc_st) - CNT_W'(w_pop);
        end
    end

    // Load FSM, memory strobes and writeback outputs.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= S_IDLE;
            r_ld_rd     <= {RD_W{1'b0}};
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_wb_valid  <= 1'b0;
            r_wb_rd     <= {RD_W{1'b0}};
            r_wb_data   <= {DATA_W{1'b0}};
        end else begin
            case (r_state)
                S_IDLE:    r_state <= w_ld_mem ? S_LD_ADDR : S_IDLE;
                S_LD_ADDR: r_state <= S_LD_DATA;
                S_LD_DATA: r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
            r_mem_read  <= w_ld_mem;
            r_mem_write <= w_pop;
            if (w_ld_mem) begin
                r_mem_addr <= bus.ex_addr;
            end else if (w_pop) begin
                r_mem_addr  <= r_sb_addr[r_head];
                r_mem_wdata <= r_sb_data[r_head];
            end
            if (w_acc_ld) begin
                r_ld_rd <= bus.ex_rd;
            end
            r_wb_valid <= 1'b0;
            if (r_state == S_LD_DATA) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= r_ld_rd;
                r_wb_data  <= bus.mem_rdata;
            end else if (w_acc_ld & w_fwd_hit) begin
                r_wb_valid <= 1'b1;
                r_wb_rd    <= bus.ex_rd;
                r_wb_data  <= w_fwd_data;
            end
        end
    end
endmodule
